// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_queue
// Purpose  : Writeback FIFO between the MEM stage and the regfile write port.
//            Optional youngest-match forwarding search under WB_FWD_EN.
// Revision : 1.0
// ============================================================================
module wb_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_we,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_we,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
`ifdef WB_FWD_EN
    input  logic [ADDR_W-1:0]          fwd_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data,
`endif
    output logic [31:0]                retire_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [31:0]       retire_q, retire_d;
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_mem_d [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_d [DEPTH];

    logic w_push, w_store, w_pop, w_nonempty;

    assign w_nonempty = (count_q != '0);
    assign in_ready   = (count_q != c_full);
    assign out_valid  = w_nonempty;
    assign out_we     = w_nonempty;
    assign out_addr   = w_nonempty ? addr_mem_q[head_q] : '0;
    assign out_data   = w_nonempty ? data_mem_q[head_q] : '0;
    assign count_out  = count_q;
    assign retire_cnt = retire_q;

    // Writes to x0 or with we=0 are handshaken but never occupy a slot.
    assign w_push  = in_valid & in_ready & rdy_in;
    assign w_store = w_push & in_we & (in_addr != '0);
    assign w_pop   = w_nonempty & out_ready & rdy_in;

    always_comb begin
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        retire_d   = retire_q;
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        if (w_store) begin
            addr_mem_d[tail_q] = in_addr;
            data_mem_d[tail_q] = in_data;
            tail_d             = tail_q + PTR_W'(1);
        end
        if (w_pop) begin
            head_d   = head_q + PTR_W'(1);
            retire_d = retire_q + 32'd1;
        end
        case ({w_store, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            retire_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            retire_q   <= retire_d;
            addr_mem_q <= addr_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

`ifdef WB_FWD_EN
    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (fwd_addr != '0) &&
                (addr_mem_q[idx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem_q[idx];
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_queue
// Purpose  : Self-checking bench for wb_queue, directed scenarios plus
//            random traffic compared against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_wb_queue;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, rdy, in_valid, in_we, out_ready;
    logic [4:0]  in_addr, fwd_addr;
    logic [31:0] in_data;
    logic        in_ready, out_valid, out_we;
    logic [4:0]  out_addr;
    logic [31:0] out_data, retire_cnt;
    logic [1:0]  count_out;
`ifdef WB_FWD_EN
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    int n_cmp = 0;
    int n_err = 0;

    ent_t        m_q[$];
    logic [31:0] m_retire = 32'd0;

    wb_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .rdy_in    (rdy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_we     (in_we),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_we    (out_we),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .count_out (count_out),
`ifdef WB_FWD_EN
        .fwd_addr  (fwd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
`endif
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic ordy, input logic r,
                         input logic rs);
        in_valid  = v;
        in_we     = we;
        in_addr   = a;
        in_data   = d;
        out_ready = ordy;
        rdy       = r;
        rst       = rs;
    endtask

    task automatic check_all();
        logic        e_hit;
        logic [31:0] e_fd;
        check_eq("in_ready",   32'(in_ready),   32'(m_q.size() != DEPTH));
        check_eq("out_valid",  32'(out_valid),  32'(m_q.size() != 0));
        check_eq("out_we",     32'(out_we),     32'(m_q.size() != 0));
        check_eq("out_addr",   32'(out_addr),   (m_q.size() != 0) ? 32'(m_q[0].a) : 32'd0);
        check_eq("out_data",   out_data,        (m_q.size() != 0) ? m_q[0].d : 32'd0);
        check_eq("count_out",  32'(count_out),  32'(m_q.size()));
        check_eq("retire_cnt", retire_cnt,      m_retire);
        e_hit = 1'b0;
        e_fd  = 32'd0;
        foreach (m_q[i]) begin
            if (fwd_addr != 5'd0 && m_q[i].a == fwd_addr) begin
                e_hit = 1'b1;
                e_fd  = m_q[i].d;
            end
        end
`ifdef WB_FWD_EN
        check_eq("fwd_hit",  32'(fwd_hit), 32'(e_hit));
        check_eq("fwd_data", fwd_data,     e_fd);
`endif
    endtask

    // Advance one clock: model sees the inputs applied before the edge.
    task automatic cycle();
        bit do_pop, do_push;
        do_pop  = 1'b0;
        do_push = 1'b0;
        if (rst) begin
            m_q.delete();
            m_retire = 32'd0;
        end else if (rdy) begin
            do_pop  = (m_q.size() != 0) && out_ready;
            do_push = in_valid && (m_q.size() != DEPTH) && in_we && (in_addr != 5'd0);
            if (do_pop) begin
                void'(m_q.pop_front());
                m_retire = m_retire + 32'd1;
            end
            if (do_push) m_q.push_back('{a: in_addr, d: in_data});
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        fwd_addr = 5'd0;
        drive(0, 0, 0, 0, 0, 1, 1);
        cycle();
        check_eq("rst_count", 32'(count_out), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // single push visible next cycle
        drive(1, 1, 5'd3, 32'hDEADBEEF, 0, 1, 0);
        cycle();
        check_eq("push1_valid", 32'(out_valid), 32'd1);
        check_eq("push1_addr",  32'(out_addr),  32'd3);
        check_eq("push1_data",  out_data,       32'hDEADBEEF);
        check_eq("push1_count", 32'(count_out), 32'd1);

        // fill, overflow attempt, drain in order
        drive(0, 0, 0, 0, 0, 1, 1);
        cycle();
        drive(1, 1, 5'd1, 32'hA1, 0, 1, 0); cycle();
        drive(1, 1, 5'd2, 32'hA2, 0, 1, 0); cycle();
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        drive(1, 1, 5'd7, 32'hA7, 0, 1, 0); cycle();
        check_eq("full_count", 32'(count_out), 32'd2);
        drive(0, 0, 0, 0, 1, 1, 0);
        check_eq("drain_first", 32'(out_addr), 32'd1);
        cycle();
        check_eq("drain_second", 32'(out_addr), 32'd2);
        cycle();
        check_eq("drain_retire", retire_cnt, 32'd2);
        check_eq("drain_empty",  32'(out_valid), 32'd0);

        // discarded writes
        drive(1, 1, 5'd0, 32'h55, 0, 1, 0); cycle();
        drive(1, 0, 5'd4, 32'h66, 0, 1, 0); cycle();
        check_eq("discard_count", 32'(count_out), 32'd0);
        check_eq("discard_valid", 32'(out_valid), 32'd0);

`ifdef WB_FWD_EN
        fwd_addr = 5'd5;
        drive(1, 1, 5'd5, 32'h11, 0, 1, 0); cycle();
        drive(1, 1, 5'd5, 32'h22, 0, 1, 0); cycle();
        check_eq("fwd_young_hit",  32'(fwd_hit), 32'd1);
        check_eq("fwd_young_data", fwd_data,     32'h22);
        fwd_addr = 5'd0;
        #1;
        check_eq("fwd_zero_hit", 32'(fwd_hit), 32'd0);
        drive(0, 0, 0, 0, 1, 1, 0); cycle(); cycle();
`endif

        // stall holds state, then reset discards entries
        drive(1, 1, 5'd9, 32'hB9, 0, 1, 0);  cycle();
        drive(1, 1, 5'd10, 32'hBA, 0, 1, 0); cycle();
        drive(1, 1, 5'd11, 32'hBB, 1, 0, 0);
        cycle(); cycle(); cycle();
        check_eq("stall_count", 32'(count_out), 32'd2);
        drive(0, 0, 0, 0, 1, 1, 1); cycle();
        check_eq("mid_rst_count",  32'(count_out), 32'd0);
        check_eq("mid_rst_retire", retire_cnt,     32'd0);
        check_eq("mid_rst_valid",  32'(out_valid), 32'd0);

        // steady push+pop at count 1
        drive(1, 1, 5'd20, 32'hC0, 0, 1, 0); cycle();
        for (int i = 1; i <= 10; i++) begin
            drive(1, 1, 5'(20 + i), 32'hC0 + 32'(i), 1, 1, 0);
            cycle();
            check_eq("stream_addr", 32'(out_addr), 32'(20 + i));
        end
        check_eq("stream_count",  32'(count_out), 32'd1);
        check_eq("stream_retire", retire_cnt,     32'd10);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 85,
                  5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 85,
                  $urandom_range(0, 99) < 2);
            fwd_addr = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width.
REQ-003 SHALL have parameter DEPTH, default 2, entry count; power of two, at least 2.
REQ-004 SHALL have port clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_in  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port rdy_in  input  1  global enable; when 0, no state changes.
REQ-007 SHALL have port in_valid  input  1  MEM stage presents a writeback.
REQ-008 SHALL have port in_ready  output  1  queue accepts this cycle.
REQ-009 SHALL have port in_we, in_addr, in_data  input  1/ADDR_W/DATA_W  write enable, destination, value.
REQ-010 SHALL have port out_valid  output  1  head entry present.
REQ-011 SHALL have port out_ready  input  1  regfile write port free.
REQ-012 SHALL have port out_we, out_addr, out_data  output  1/ADDR_W/DATA_W  regfile write request.
REQ-013 SHALL have port count_out  output  clog2(DEPTH+1)  occupied entries.
REQ-014 SHALL have port retire_cnt  output  32  completed regfile writes.
REQ-015 SHALL have, under WB_FWD_EN only, port fwd_addr  input  ADDR_W, fwd_hit  output  1, and fwd_data  output  DATA_W.

Function
REQ-016 SHALL perform a push when in_valid, in_ready and rdy_in are all 1.
REQ-017 SHALL perform a pop when out_valid, out_ready and rdy_in are all 1.
REQ-018 SHALL drive in_ready = (count_out != DEPTH), from registered state only; a pop in the same cycle does not raise it.
REQ-019 SHALL treat a push with in_we=0 or in_addr=0 as accepted but discarded: no entry stored, count unchanged.
REQ-020 SHALL make a stored push visible at the outputs the next cycle; latency 1, no combinational in-to-out path.
REQ-021 SHALL present the oldest entry on out_addr/out_data, with out_we = out_valid = (count_out != 0).
REQ-022 SHALL drive out_addr and out_data to 0 when the queue is empty.
REQ-023 SHALL, on simultaneous push and pop with 0 < count < DEPTH, keep count unchanged and preserve FIFO order.
REQ-024 SHALL run head/tail pointers modulo DEPTH with wrap-around, using no extra storage.
REQ-025 SHALL increment retire_cnt by 1 per pop, wrapping from 0xFFFFFFFF to 0.
REQ-026 SHALL, when rdy_in=0, hold all state, treat pushes and pops as not performed, and keep outputs stable.

Reset
REQ-027 SHALL, when rst_in=1 at a clock edge, clear count, pointers and retire_cnt to 0 and all entries to 0, regardless of rdy_in or pending handshakes.
REQ-028 SHALL, in the cycle after reset, drive in_ready=1, out_valid=0, out_we=0, out_addr=0, out_data=0, count_out=0, retire_cnt=0, and fwd_hit=0 if WB_FWD_EN is defined.
REQ-029 SHALL discard queued entries when reset is asserted mid-operation; nothing is popped.

Configuration
REQ-030 SHALL, with macro WB_FWD_EN defined, combinationally search stored entries for fwd_addr; fwd_hit=1 and fwd_data = youngest match; fwd_addr=0 never hits; no match gives fwd_hit=0, fwd_data=0.
REQ-031 SHALL exclude the same-cycle in_* input from the forwarding search.
REQ-032 SHALL, without WB_FWD_EN, omit the fwd_* ports and search logic entirely; all other behaviour is identical.

Verification
REQ-033 Bench SHALL cover: reset, then push (we=1, addr=3, data=0xDEADBEEF) with out_ready=0 -> next cycle out_valid=1, out_addr=3, out_data=0xDEADBEEF, count_out=1.
REQ-034 Bench SHALL cover: DEPTH=2, push addr 1 then addr 2 with out_ready=0 -> in_ready=0; third push ignored; out_ready=1 for two cycles -> addr 1 then addr 2 popped, retire_cnt=2.
REQ-035 Bench SHALL cover: push with addr=0 or we=0 -> count_out stays 0, out_valid stays 0.
REQ-036 Bench SHALL cover: WB_FWD_EN, queue holds (5,0x11) then (5,0x22), fwd_addr=5 -> fwd_hit=1, fwd_data=0x22; fwd_addr=0 -> fwd_hit=0.
REQ-037 Bench SHALL cover: two entries queued, rdy_in=0 with out_ready=1 for 3 cycles -> no pops; then rst_in=1 for one cycle -> count_out=0, retire_cnt=0, out_valid=0.
REQ-038 Bench SHALL cover: continuous push+pop for 10 cycles at count=1 -> count stays 1, pointers wrap, order preserved, retire_cnt=10.
